// File: rtl/mul_seq_if.sv
// Request/response bundle for the iterative RV32M multiply sequencer.
// The op encoding package is guarded so either rtl file may be compiled first.
`ifndef MUL_SEQ_PKG_DEFINED
`define MUL_SEQ_PKG_DEFINED
package mul_seq_pkg;
  typedef enum logic [1:0] {MUL_MUL, MUL_MULH, MUL_MULHU, MUL_MULHSU} mul_op_t;
endpackage
`endif

interface mul_seq_if;
  import mul_seq_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] a;
  logic [31:0] b;
  mul_op_t     op;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] res;
  logic        busy;

  modport master (
    output req_valid, a, b, op, flush, rsp_ready,
    input  req_ready, rsp_valid, res, busy
  );

  modport slave (
    input  req_valid, a, b, op, flush, rsp_ready,
    output req_ready, rsp_valid, res, busy
  );
endinterface

// File: rtl/mul_seq.sv
// Multi-cycle sign-magnitude shift-add multiplier for MUL/MULH/MULHU/MULHSU.
// Optional last-product cache enabled by defining MUL_FUSE_EN.
`ifndef MUL_SEQ_PKG_DEFINED
`define MUL_SEQ_PKG_DEFINED
package mul_seq_pkg;
  typedef enum logic [1:0] {MUL_MUL, MUL_MULH, MUL_MULHU, MUL_MULHSU} mul_op_t;
endpackage
`endif

module mul_seq #(
  parameter int STEP_BITS = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  mul_seq_if.slave bus
);
  import mul_seq_pkg::*;

  localparam int N     = 32 / STEP_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_SIGN, S_DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      mcand;
  logic [63:0]      acc;
  logic [63:0]      prod;
  logic [31:0]      mplier;
  logic [31:0]      res_q;
  logic             neg;
  mul_op_t          op_q;
  logic             a_sgn;
  logic             b_sgn;
  logic             a_neg;
  logic             b_neg;
  logic             accept;
  logic             hit;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_neg);
    return is_neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic is_neg);
    return is_neg ? (~v + 64'd1) : v;
  endfunction

  function automatic logic [63:0] partial(input logic [63:0] mc,
                                          input logic [STEP_BITS-1:0] d);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < STEP_BITS; i++)
      if (d[i]) s = s + (mc << i);
    return s;
  endfunction

  function automatic logic [31:0] pick(input mul_op_t o, input logic [63:0] p);
    return (o == MUL_MUL) ? p[31:0] : p[63:32];
  endfunction

  assign a_sgn  = (bus.op != MUL_MULHU);
  assign b_sgn  = (bus.op == MUL_MUL) || (bus.op == MUL_MULH);
  assign a_neg  = a_sgn & bus.a[31];
  assign b_neg  = b_sgn & bus.b[31];
  assign accept = (state == S_IDLE) && bus.req_valid && !bus.flush;
  assign prod   = cneg64(acc, neg);

`ifdef MUL_FUSE_EN
  logic        c_vld;
  logic        c_sa;
  logic        c_sb;
  logic        sa_q;
  logic        sb_q;
  logic [31:0] c_a;
  logic [31:0] c_b;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] c_p;

  // MUL low word is independent of signedness, so any cached pair serves it.
  assign hit = c_vld && (bus.a == c_a) && (bus.b == c_b) &&
               ((bus.op == MUL_MUL) || ((a_sgn == c_sa) && (b_sgn == c_sb)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           c_vld <= 1'b0;
    else if (bus.flush && state != S_IDLE)  c_vld <= 1'b0;
    else if (state == S_SIGN)               c_vld <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      sa_q <= a_sgn;
      sb_q <= b_sgn;
    end
    if (state == S_SIGN && !bus.flush) begin
      c_a  <= a_q;
      c_b  <= b_q;
      c_sa <= sa_q;
      c_sb <= sb_q;
      c_p  <= prod;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.req_valid) state_nx = hit ? S_DONE : S_BUSY;
      S_BUSY:  if (cnt == '0)     state_nx = S_SIGN;
      S_SIGN:                     state_nx = S_DONE;
      S_DONE:  if (bus.rsp_ready) state_nx = S_IDLE;
      default:                    state_nx = S_IDLE;
    endcase
    // Kill wins over both accept and the response handshake.
    if (bus.flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nx;
      if (accept)
        cnt <= CNT_W'(N - 1);
      else if (state == S_BUSY && cnt != '0)
        cnt <= cnt - 1'b1;
      if (!bus.flush) begin
        if (state == S_SIGN)
          res_q <= pick(op_q, prod);
`ifdef MUL_FUSE_EN
        else if (accept && hit)
          res_q <= pick(bus.op, c_p);
`endif
      end
    end
  end

  // Iteration: one multiplier digit per cycle, multiplicand pre-shifted to the digit weight.
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand  <= {32'd0, mag32(bus.a, a_neg)};
      mplier <= mag32(bus.b, b_neg);
      acc    <= '0;
      neg    <= a_neg ^ b_neg;
      op_q   <= bus.op;
    end else if (state == S_BUSY) begin
      acc    <= acc + partial(mcand, mplier[STEP_BITS-1:0]);
      mcand  <= mcand << STEP_BITS;
      mplier <= mplier >> STEP_BITS;
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.rsp_valid = (state == S_DONE);
  assign bus.res       = res_q;
endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: scoreboard of expected results, latency and handshake checks.
// Fuse-cache steps are compiled in only when MUL_FUSE_EN is defined.
`ifndef MUL_SEQ_PKG_DEFINED
`define MUL_SEQ_PKG_DEFINED
package mul_seq_pkg;
  typedef enum logic [1:0] {MUL_MUL, MUL_MULH, MUL_MULHU, MUL_MULHSU} mul_op_t;
endpackage
`endif

module tb_mul_seq;
  import mul_seq_pkg::*;

  localparam int STEP_BITS = 4;
  localparam int N         = 32 / STEP_BITS;
`ifdef MUL_FUSE_EN
  localparam bit FUSE = 1'b1;
`else
  localparam bit FUSE = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  mul_seq_if bus();

  mul_seq #(.STEP_BITS(STEP_BITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  logic        c_vld  = 1'b0;
  logic [31:0] c_a    = '0;
  logic [31:0] c_b    = '0;
  logic        c_sa   = 1'b0;
  logic        c_sb   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input mul_op_t op);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op == MUL_MULHU) ? {32'd0, a} : {{32{a[31]}}, a};
    eb = (op == MUL_MULHU || op == MUL_MULHSU) ? {32'd0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    return (op == MUL_MUL) ? p[31:0] : p[63:32];
  endfunction

  // One full transaction; hold = cycles rsp_ready is kept low once the result shows.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input mul_op_t op,
                        input logic [31:0] exp, input int hold, input string tag);
    logic        sa;
    logic        sb;
    logic        hit;
    logic        mid_ok;
    logic        stable;
    logic [31:0] r0;
    logic [31:0] e;
    int          lat;
    sa  = (op != MUL_MULHU);
    sb  = (op == MUL_MUL) || (op == MUL_MULH);
    hit = FUSE && c_vld && (a == c_a) && (b == c_b) &&
          ((op == MUL_MUL) || ((sa == c_sa) && (sb == c_sb)));
    @(negedge clk);
    check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.a         = a;
    bus.b         = b;
    bus.op        = op;
    bus.rsp_ready = (hold == 0);
    bus.req_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat    = 0;
    mid_ok = 1'b1;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.rsp_valid === 1'b1) break;
      if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) mid_ok = 1'b0;
    end
    check({tag, ".latency"}, 32'(lat), hit ? 32'd1 : 32'(N + 1));
    check({tag, ".busy_between"}, 32'(mid_ok), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    check({tag, ".res"}, bus.res, e);
    if (hold > 0) begin
      r0     = bus.res;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (bus.rsp_valid !== 1'b1 || bus.res !== r0 || bus.req_ready !== 1'b0) stable = 1'b0;
      end
      check({tag, ".hold_stable"}, 32'(stable), 32'd1);
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, ".after_hs"}, {29'd0, bus.rsp_valid, bus.req_ready, bus.busy}, 32'b010);
    if (!hit) begin
      c_vld = 1'b1;
      c_a   = a;
      c_b   = b;
      c_sa  = sa;
      c_sb  = sb;
    end
  endtask

  task automatic watch_no_rsp(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    check({tag, ".no_rsp"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    mul_op_t     rop;
    bus.req_valid = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = MUL_MUL;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.req_ready", 32'(bus.req_ready), 32'd1);
    check("rst.res", bus.res, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(32'd3, 32'd5, MUL_MUL, 32'h0000000F, 0, "t1.mul");

    run_op(32'd3, 32'hFFFFFFFB, MUL_MUL,    32'hFFFFFFF1, 0, "t2.mul");
    run_op(32'd3, 32'hFFFFFFFB, MUL_MULH,   32'hFFFFFFFF, 0, "t2.mulh");
    run_op(32'd3, 32'hFFFFFFFB, MUL_MULHU,  32'h00000002, 0, "t2.mulhu");
    run_op(32'd3, 32'hFFFFFFFB, MUL_MULHSU, 32'h00000002, 0, "t2.mulhsu");

    run_op(32'h80000000, 32'h80000000, MUL_MULH,  32'h40000000, 0, "t3.minmin");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, MUL_MULHU, 32'hFFFFFFFE, 0, "t3.maxhu");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, MUL_MUL,   32'h00000001, 0, "t3.m1m1");
    run_op(32'd0, 32'd0, MUL_MULH, 32'd0, 0, "t3.zero");

    run_op(32'd11, 32'd13, MUL_MUL, 32'd143, 5, "t4.backpressure");

    // Flush during the third BUSY cycle.
    @(negedge clk);
    bus.a = 32'd9; bus.b = 32'd9; bus.op = MUL_MULHU; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    c_vld = 1'b0;
    check("t5.flush_idle", {29'd0, bus.rsp_valid, bus.req_ready, bus.busy}, 32'b010);
    watch_no_rsp("t5.flush");

    // Asynchronous reset during BUSY.
    @(negedge clk);
    bus.a = 32'd5; bus.b = 32'd5; bus.op = MUL_MUL; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    check("t5.rst_idle", {29'd0, bus.rsp_valid, bus.req_ready, bus.busy}, 32'b010);
    check("t5.rst_res", bus.res, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    c_vld = 1'b0;
    watch_no_rsp("t5.rst");

    // Flush in IDLE blocks a simultaneous request.
    @(negedge clk);
    bus.a = 32'd2; bus.b = 32'd2; bus.op = MUL_MUL; bus.req_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    check("t5.flush_idle_req", 32'(bus.busy), 32'd0);
    watch_no_rsp("t5.flush_idle_req");

    run_op(32'd7, 32'd6, MUL_MUL, 32'd42, 0, "t5.after");

    for (int i = 0; i < 4; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = mul_op_t'(2'($urandom_range(0, 3)));
      run_op(ra, rb, rop, model(ra, rb, rop), 0, "rand");
    end

`ifdef MUL_FUSE_EN
    run_op(32'd3, 32'hFFFFFFFB, MUL_MUL,   32'hFFFFFFF1, 0, "t6.mul");
    run_op(32'd3, 32'hFFFFFFFB, MUL_MULH,  32'hFFFFFFFF, 0, "t6.mulh_hit");
    run_op(32'd3, 32'hFFFFFFFB, MUL_MULHU, 32'h00000002, 0, "t6.mulhu_miss");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
